fifo_rd_stream: RTL and testbench

- Read-side adapter placed directly downstream of the team's synchronous FIFO.
- Drives the FIFO's read strobe from its empty flag.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer.
- Presents the data to the next stage as a valid/ready stream. Full throughput (one word per clock) is required when the FIFO is non-empty and the sink is ready.

---
 rtl/fifo_rd_stream.sv | 100 ++++++++++
 tb/tb_fifo_rd_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read-side adapter with a 2-entry output buffer and a valid/ready stream; define FIFO_RD_STATS_EN for transfer/stall counters
module fifo_rd_stream #(
   parameter int WIDTH = 16,
   parameter int SKID  = 2,
   localparam int CW   = $clog2(SKID) + 1
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data_out,
   output logic             fifo_read,
   input  logic             flush,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   input  logic             m_ready,
   output logic [CW-1:0]    rd_count
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [31:0]      stat_words,
   output logic [31:0]      stat_stalls
`endif
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

   occ_t             state, state_nxt;
   logic             inflight, push, pop, wr0, shift;
   logic [2:0]       level;
   logic [WIDTH-1:0] entry0, entry1;

   if (SKID != 2) begin : g_skid_check
      $error("fifo_rd_stream: SKID must be 2");
   end

   assign pop       = m_valid && m_ready;
   assign push      = inflight && !flush;
   assign level     = {1'b0, state} + {2'b0, inflight} - {2'b0, pop};
   assign fifo_read = rst_ && !fifo_empty && !flush && level < 3'd2;
   assign wr0       = push && (state == EMPTY || (state == ONE && pop));
   assign shift     = state == TWO && pop;
   assign m_valid   = state != EMPTY;
   assign m_data    = entry0;
   assign rd_count  = CW'(state);

   // Occupancy next state: flush empties the buffer, otherwise follow push/pop
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   state_nxt = push ? ONE : EMPTY;
         ONE:     state_nxt = push && !pop ? TWO : !push && pop ? EMPTY : ONE;
         TWO:     state_nxt = pop ? ONE : TWO;
         default: state_nxt = EMPTY;
      endcase
      if (flush) state_nxt = EMPTY;
   end

   // Occupancy register and the read-latency tracker
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state    <= EMPTY;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= fifo_read;
      end
   end

   // Buffer: entry0 is the head; entry1 takes a word that arrives behind a held head
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         entry0 <= '0;
         entry1 <= '0;
      end else begin
         if (wr0) entry0 <= fifo_data_out;
         else if (shift) entry0 <= entry1;
         if (push && !wr0) entry1 <= fifo_data_out;
      end
   end

   // A word landing on a full buffer would be lost; the read issue rule must prevent it
   assert property (@(posedge clk) disable iff (!rst_) !(state == TWO && push && !pop))
      else $error("fifo_rd_stream: push into full buffer");

`ifdef FIFO_RD_STATS_EN
   // Debug counters for completed transfers and back-pressured cycles; flush clears them
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         stat_words  <= '0;
         stat_stalls <= '0;
      end else if (flush) begin
         stat_words  <= '0;
         stat_stalls <= '0;
      end else begin
         stat_words  <= stat_words + {31'b0, pop};
         stat_stalls <= stat_stalls + {31'b0, m_valid && !m_ready};
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: vector table, directed corner cases and a random run against a queue-based reference model
module tb_fifo_rd_stream;

   typedef struct packed {
      logic [3:0]  ld_n;
      logic [15:0] ld_base;
      logic        rdy;
      logic        fl;
      logic        e_read;
      logic        e_valid;
      logic [15:0] e_data;
      logic [1:0]  e_cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic        fifo_empty = 1'b1;
   logic        flush = 1'b0;
   logic        m_ready = 1'b0;
   logic [15:0] fifo_data_out = '0;
   logic        fifo_read, m_valid;
   logic [15:0] m_data;
   logic [1:0]  rd_count;
`ifdef FIFO_RD_STATS_EN
   logic [31:0] stat_words, stat_stalls;
`endif

   logic [15:0] fq[$];
   logic [15:0] pend[$];
   logic [15:0] dlv[$];
   bit          rd_last;
   logic [15:0] rd_word;
   logic [31:0] m_words, m_stalls;
   int          errs, checks, max_cnt;
   vec_t        tv[$];

   always #5 clk = ~clk;

   fifo_rd_stream #(.WIDTH(16), .SKID(2)) dut (
      .clk(clk),
      .rst_(rst_),
      .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out),
      .fifo_read(fifo_read),
      .flush(flush),
      .m_valid(m_valid),
      .m_data(m_data),
      .m_ready(m_ready),
      .rd_count(rd_count)
`ifdef FIFO_RD_STATS_EN
      ,
      .stat_words(stat_words),
      .stat_stalls(stat_stalls)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   function automatic vec_t mk(int n, int b, bit r, bit f, bit er, bit ev, int ed, int ec);
      vec_t t;
      t.ld_n = 4'(n);
      t.ld_base = 16'(b);
      t.rdy = r;
      t.fl = f;
      t.e_read = er;
      t.e_valid = ev;
      t.e_data = 16'(ed);
      t.e_cnt = 2'(ec);
      return t;
   endfunction

   // One clock cycle: drive at negedge, check against the model, advance the model for the coming posedge
   task automatic step(input bit rdy, input bit fl, output bit a_read, output bit a_valid,
                       output logic [15:0] a_data, output logic [1:0] a_cnt);
      int          eo;
      bit          ev, pop, er, rd;
      logic [15:0] w;
      @(negedge clk);
      fifo_data_out = rd_last ? rd_word : 16'($urandom);
      m_ready = rdy;
      flush = fl;
      fifo_empty = (fq.size() == 0);
      #1;
      eo = pend.size() - int'(rd_last);
      ev = eo != 0;
      pop = ev && rdy;
      er = !fifo_empty && !fl && (pend.size() - int'(pop) < 2);
      chk("fifo_read", 32'(fifo_read), 32'(er));
      chk("m_valid", 32'(m_valid), 32'(ev));
      chk("rd_count", 32'(rd_count), 32'(eo));
      if (ev) chk("m_data", 32'(m_data), 32'(pend[0]));
`ifdef FIFO_RD_STATS_EN
      chk("stat_words", stat_words, m_words);
      chk("stat_stalls", stat_stalls, m_stalls);
`endif
      a_read = fifo_read;
      a_valid = m_valid;
      a_data = m_data;
      a_cnt = rd_count;
      if (int'(rd_count) > max_cnt) max_cnt = int'(rd_count);
      if (pop) begin
         dlv.push_back(pend[0]);
         void'(pend.pop_front());
      end
      rd = fifo_read && !fifo_empty;
      w = rd ? fq.pop_front() : 16'h0;
      m_words = fl ? 32'd0 : m_words + (pop ? 32'd1 : 32'd0);
      m_stalls = fl ? 32'd0 : m_stalls + (ev && !rdy ? 32'd1 : 32'd0);
      if (fl) pend.delete();
      else if (rd) pend.push_back(w);
      rd_last = rd && !fl;
      rd_word = w;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ = 1'b0;
      fifo_empty = (fq.size() == 0);
      pend.delete();
      rd_last = 1'b0;
      m_words = '0;
      m_stalls = '0;
      #1;
      chk("rst_fifo_read", 32'(fifo_read), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_rd_count", 32'(rd_count), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
`ifdef FIFO_RD_STATS_EN
      chk("rst_stat_words", stat_words, 32'd0);
      chk("rst_stat_stalls", stat_stalls, 32'd0);
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_fifo_read", 32'(fifo_read), 32'd0);
      chk("rst_hold_m_valid", 32'(m_valid), 32'd0);
      #1 rst_ = 1'b1;
   endtask

   initial begin
      bit          ar, av;
      logic [15:0] ad;
      logic [1:0]  ac;
      logic [11:0] pat;
      errs = 0;
      checks = 0;
      max_cnt = 0;
      rd_last = 1'b0;
      rd_word = '0;
      m_words = '0;
      m_stalls = '0;
      // streaming 1..4 with the sink always ready (words preloaded before reset)
      tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
      tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
      tv.push_back(mk(0, 0, 1, 0, 1, 1, 1, 1));
      tv.push_back(mk(0, 0, 1, 0, 1, 1, 2, 1));
      tv.push_back(mk(0, 0, 1, 0, 0, 1, 3, 1));
      tv.push_back(mk(0, 0, 1, 0, 0, 1, 4, 1));
      tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
      // back-pressure: 3 words, sink stalled 5 cycles
      tv.push_back(mk(3, 1, 0, 0, 1, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1));
      tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2));
      tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2));
      tv.push_back(mk(0, 0, 1, 0, 1, 1, 1, 2));
      tv.push_back(mk(0, 0, 1, 0, 0, 1, 2, 1));
      tv.push_back(mk(0, 0, 1, 0, 0, 1, 3, 1));
      tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
      // flush with a full buffer, then flush with a word in flight
      tv.push_back(mk(5, 'h10, 0, 0, 1, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 0, 1, 'h10, 1));
      tv.push_back(mk(0, 0, 1, 1, 0, 1, 'h10, 2));
      tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
      tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
      tv.push_back(mk(0, 0, 1, 0, 1, 1, 'h12, 1));
      tv.push_back(mk(0, 0, 0, 1, 0, 1, 'h13, 1));
      tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) fq.push_back(16'(k + 1));
      do_reset();
      foreach (tv[i]) begin
         for (int k = 0; k < int'(tv[i].ld_n); k++) fq.push_back(tv[i].ld_base + 16'(k));
         step(tv[i].rdy, tv[i].fl, ar, av, ad, ac);
         chk($sformatf("vec%0d_read", i), 32'(ar), 32'(tv[i].e_read));
         chk($sformatf("vec%0d_valid", i), 32'(av), 32'(tv[i].e_valid));
         chk($sformatf("vec%0d_count", i), 32'(ac), 32'(tv[i].e_cnt));
         if (tv[i].e_valid) chk($sformatf("vec%0d_data", i), 32'(ad), 32'(tv[i].e_data));
      end
      // alternating ready over 8 words: all delivered once, in order, occupancy bounded
      dlv.delete();
      max_cnt = 0;
      for (int k = 0; k < 8; k++) fq.push_back(16'hA000 + 16'(k));
      for (int c = 0; c < 60 && dlv.size() < 8; c++) step(c % 2 == 0, 1'b0, ar, av, ad, ac);
      chk("alt_count", 32'(dlv.size()), 32'd8);
      for (int k = 0; k < 8; k++)
         chk($sformatf("alt_word%0d", k), k < dlv.size() ? 32'(dlv[k]) : 32'hdead, 32'(16'hA000 + 16'(k)));
      chk("alt_max_occ", 32'(max_cnt <= 2), 32'd1);
`ifdef FIFO_RD_STATS_EN
      step(1'b1, 1'b1, ar, av, ad, ac);
      step(1'b1, 1'b0, ar, av, ad, ac);
      chk("stats_start_words", stat_words, 32'd0);
      for (int k = 0; k < 6; k++) fq.push_back(16'hB000 + 16'(k));
      pat = 12'b1111_1110_0011;
      for (int c = 0; c < 12; c++) step(pat[c], 1'b0, ar, av, ad, ac);
      step(1'b1, 1'b0, ar, av, ad, ac);
      chk("stats_words6", stat_words, 32'd6);
      chk("stats_stalls3", stat_stalls, 32'd3);
      step(1'b1, 1'b1, ar, av, ad, ac);
      step(1'b1, 1'b0, ar, av, ad, ac);
      chk("stats_flush_words", stat_words, 32'd0);
      chk("stats_flush_stalls", stat_stalls, 32'd0);
`endif
      // random traffic with occasional flushes and one reset mid-stream
      for (int c = 0; c < 600; c++) begin
         if (fq.size() < 6 && $urandom_range(1, 0) == 1) fq.push_back(16'($urandom));
         if (c == 300) do_reset();
         step($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 4, ar, av, ad, ac);
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
